// File: rtl/mul_sequencer_pkg.sv
// rtl/mul_sequencer_pkg.sv - shared encodings for the iterative multiply unit
//
// Purpose: operation and FSM state encodings used by mul_sequencer and its datapath.
// Contents:
//   mulop_e       MulOp encodings (11 is reserved and executes as UMULL)
//   state_e       sequencer states IDLE/CALC/FIX/DONE
//   op_is_signed  true only for SMULL, the one op that works on magnitudes

package mul_sequencer_pkg;

    typedef enum logic [1:0] {
        MULOP_MUL   = 2'b00,
        MULOP_UMULL = 2'b01,
        MULOP_SMULL = 2'b10,
        MULOP_RSVD  = 2'b11
    } mulop_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return op == MULOP_SMULL;
    endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// rtl/mul_shift_add_dp.sv - shift-add multiply datapath: operands, accumulator, counter, fix-up
//
// Purpose: holds the operand, accumulator and iteration-counter registers of the
// sequential multiplier and produces the sign-corrected, flagged result.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   load                  latch op/operands, clear accumulator, arm counter
//   step                  one shift-add iteration
//   fix                   apply sign correction and register results/flags
//   mulop                 operation code presented with load
//   srca, srcb            multiplicand / multiplier presented with load
//   count_zero            last iteration is the current one
//   result_lo, result_hi  registered product halves (hi forced 0 for MUL)
//   mul_n, mul_z          registered negative / zero flags

module mul_shift_add_dp
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic [1:0]       mulop,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             count_zero,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             mul_n,
    output logic             mul_z
);

    localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]         op_q;
    logic               neg_q;
    // Multiplicand lives in a double-width register and is shifted left each
    // iteration, so the accumulator add is always the same full-width add.
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      count_q;

    logic               load_signed;
    logic               neg_d;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;
    logic               is_mul;
    logic [WIDTH-1:0]   lo_d;
    logic [WIDTH-1:0]   hi_d;
    logic               n_d;
    logic               z_d;

    // Magnitudes are WIDTH-bit unsigned: the most negative input maps to
    // 2^(WIDTH-1), which still fits, so no overflow handling is needed.
    always_comb begin
        load_signed = op_is_signed(mulop);
        a_mag       = (load_signed && srca[WIDTH-1]) ? -srca : srca;
        b_mag       = (load_signed && srcb[WIDTH-1]) ? -srcb : srcb;
        neg_d       = load_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
    end

    always_comb begin
        prod   = neg_q ? -acc_q : acc_q;
        is_mul = (op_q == MULOP_MUL);
        lo_d   = prod[WIDTH-1:0];
        hi_d   = is_mul ? '0 : prod[2*WIDTH-1:WIDTH];
        n_d    = is_mul ? prod[WIDTH-1] : prod[2*WIDTH-1];
        z_d    = is_mul ? (lo_d == '0) : (prod == '0);
    end

    assign count_zero = (count_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            result_lo <= '0;
            result_hi <= '0;
            mul_n     <= 1'b0;
            mul_z     <= 1'b0;
        end else begin
            if (load) begin
                op_q     <= mulop;
                neg_q    <= neg_d;
                mcand_q  <= {{WIDTH{1'b0}}, a_mag};
                mplier_q <= b_mag;
                acc_q    <= '0;
                count_q  <= CNT_INIT;
            end else if (step) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                count_q  <= count_q - CNT_ONE;
            end
            // Results only move here, so they hold across idling and across
            // a new Start until the next operation reaches its fix-up.
            if (fix) begin
                result_lo <= lo_d;
                result_hi <= hi_d;
                mul_n     <= n_d;
                mul_z     <= z_d;
            end
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - fixed-latency iterative multiply sequencer (MUL/UMULL/SMULL)
//
// Purpose: launches a shift-add multiply on Start, reports Busy while iterating and
// pulses Done one cycle when results are valid (WIDTH+2 cycles after Start).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   Start               launch request, honoured only in IDLE or DONE
//   MulOp               00 MUL, 01 UMULL, 10 SMULL, 11 treated as UMULL
//   SrcA, SrcB          operands, captured on an accepted Start
//   Busy                high in CALC and FIX
//   Done                one-cycle pulse in DONE
//   ResultLo, ResultHi  product halves (ResultHi is 0 for MUL)
//   MulN, MulZ          negative / zero flags of the product

module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       MulOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic             MulN,
    output logic             MulZ
);

    state_e state_q;
    state_e state_d;

    logic load;
    logic step;
    logic fix;
    logic count_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                Busy = 1'b1;
                step = 1'b1;
                if (count_zero) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                Busy    = 1'b1;
                fix     = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                // Done still pulses when a back-to-back Start is taken here.
                Done = 1'b1;
                if (Start) begin
                    load    = 1'b1;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mul_shift_add_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .fix       (fix),
        .mulop     (MulOp),
        .srca      (SrcA),
        .srcb      (SrcB),
        .count_zero(count_zero),
        .result_lo (ResultLo),
        .result_hi (ResultHi),
        .mul_n     (MulN),
        .mul_z     (MulZ)
    );

endmodule
